morphle_cfg_loader: RTL and testbench

- Wishbone-slave configuration sequencer that produces the Morphle block's configuration-side signals (reset, confclk, 16-bit cbitin column word) and reads back cbitout, so the RISC-V no longer bit-bangs configuration through LA pins.
- Sits in the user project between the Wishbone bus and yblock's reset/confclk/cbitin/cbitout ports.
- CPU pushes column words into a small FIFO; an FSM replays each word as one confclk pulse with programmable timing and captures cbitout at every rising edge.

---
 rtl/morphle_cfg_pkg.sv | 27 ++
 rtl/morphle_cfg_fifo.sv | 64 ++++++
 rtl/morphle_cfg_loader.sv | 202 ++++++++++++++++++++
 tb/tb_morphle_cfg_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/morphle_cfg_pkg.sv
// Shared definitions for the Morphle configuration loader: register map,
// register bit positions and the confclk sequencer state encoding.
package morphle_cfg_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RDBK   = 2'd3;

  localparam int CTRL_BLKRST   = 0;
  localparam int CTRL_HALF_LSB = 8;

  localparam int ST_BUSY      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_LEVEL_LSB = 4;
  localparam int ST_COUNT_LSB = 16;

  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2
  } state_t;

endpackage

// File: rtl/morphle_cfg_fifo.sv
// Small synchronous FIFO holding configuration column words. Exposes the head
// and the entry behind it so the sequencer can chain pulses without a bubble.
module morphle_cfg_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head_next,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic             do_push;
  logic             do_pop;

  assign empty      = (level == '0);
  assign full       = (level == LW'(DEPTH));
  assign do_pop     = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
  assign do_push    = push & (~full | do_pop);
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign head       = mem[rd_ptr];
  assign head_next  = mem[rd_ptr_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and level alone define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/morphle_cfg_loader.sv
// Wishbone slave that replays queued column words onto yblock as confclk
// pulses with programmable half-period, capturing cbitout at each rise.
module morphle_cfg_loader
  import morphle_cfg_pkg::*;
#(
  parameter int BLOCKWIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  cfg_reset_o,
  output logic                  confclk_o,
  output logic [BLOCKWIDTH-1:0] cbitin_o,
  input  logic [BLOCKWIDTH-1:0] cbitout_i,
  output logic                  busy_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  // Bus decode and register state
  logic                  valid;
  logic [1:0]            reg_sel;
  logic                  data_wr;
  logic                  stall;
  logic                  ack_set;
  logic                  wr_en;
  logic                  ctrl_wr;
  logic                  flush;
  logic                  push;
  logic [31:0]           rd_data;
  logic                  blkrst_q;
  logic [DIV_W-1:0]      half_q;
  logic [DIV_W-1:0]      half_m1;

  // FIFO interface
  logic [BLOCKWIDTH-1:0] fifo_head;
  logic [BLOCKWIDTH-1:0] fifo_head_next;
  logic [LW-1:0]         fifo_level;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_pop;

  // Sequencer state
  state_t                state_q, state_n;
  logic [DIV_W-1:0]      cnt_q, cnt_n;
  logic                  confclk_q, confclk_n;
  logic [BLOCKWIDTH-1:0] cbitin_q, cbitin_n;
  logic [BLOCKWIDTH-1:0] rdbk_q, rdbk_n;
  logic [COUNT_W-1:0]    pulse_q, pulse_n;

  logic                  unused_bits;
  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  assign valid   = wbs_cyc_i & wbs_stb_i;
  assign reg_sel = wbs_adr_i[3:2];
  assign data_wr = valid & wbs_we_i & (reg_sel == ADDR_DATA);
  // While the block is held in reset a stalled word can never drain, so it is acked and dropped.
  assign stall   = data_wr & fifo_full & ~fifo_pop & ~blkrst_q;
  assign ack_set = valid & ~wbs_ack_o & ~stall;
  assign wr_en   = valid & wbs_ack_o & wbs_we_i;
  assign ctrl_wr = wr_en & (reg_sel == ADDR_CTRL);
  assign push    = wr_en & (reg_sel == ADDR_DATA);
  assign flush   = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[CTRL_BLKRST];
  assign half_m1 = (half_q == '0) ? '0 : half_q - 1'b1;

  assign busy_o      = (state_q != S_IDLE) | ~fifo_empty;
  assign cfg_reset_o = blkrst_q;
  assign confclk_o   = confclk_q;
  assign cbitin_o    = cbitin_q;

  morphle_cfg_fifo #(
    .WIDTH (BLOCKWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .flush     (flush),
    .push      (push),
    .din       (wbs_dat_i[BLOCKWIDTH-1:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .head_next (fifo_head_next),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      ADDR_CTRL: begin
        rd_data[CTRL_BLKRST]               = blkrst_q;
        rd_data[CTRL_HALF_LSB +: DIV_W]    = half_q;
      end
      ADDR_STATUS: begin
        rd_data[ST_BUSY]                   = busy_o;
        rd_data[ST_EMPTY]                  = fifo_empty;
        rd_data[ST_FULL]                   = fifo_full;
        rd_data[ST_LEVEL_LSB +: 4]         = 4'(fifo_level);
        rd_data[ST_COUNT_LSB +: COUNT_W]   = pulse_q;
      end
      ADDR_RDBK: rd_data[BLOCKWIDTH-1:0]   = rdbk_q;
      default:   rd_data                   = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      blkrst_q  <= 1'b1;
      half_q    <= DIV_W'(1);
    end else begin
      wbs_ack_o <= ack_set;
      wbs_dat_o <= (ack_set && !wbs_we_i) ? rd_data : '0;
      if (ctrl_wr && wbs_sel_i[0]) blkrst_q <= wbs_dat_i[CTRL_BLKRST];
      if (ctrl_wr && wbs_sel_i[1]) half_q   <= wbs_dat_i[CTRL_HALF_LSB +: DIV_W];
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to its hold value so no latch is inferred.
    state_n   = state_q;
    cnt_n     = cnt_q;
    confclk_n = confclk_q;
    cbitin_n  = cbitin_q;
    rdbk_n    = rdbk_q;
    pulse_n   = pulse_q;
    fifo_pop  = 1'b0;
    if (flush || blkrst_q) begin
      state_n   = S_IDLE;
      confclk_n = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_n  = S_SETUP;
            cbitin_n = fifo_head;
            cnt_n    = half_m1;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_n   = S_HIGH;
            confclk_n = 1'b1;
            rdbk_n    = cbitout_i;
            pulse_n   = pulse_q + 1'b1;
            cnt_n     = half_m1;
          end else begin
            cnt_n = cnt_q - 1'b1;
          end
        end
        S_HIGH: begin
          if (cnt_q == '0) begin
            confclk_n = 1'b0;
            fifo_pop  = 1'b1;
            // The falling edge starts the next word's setup window directly.
            if (fifo_level > LVL_ONE) begin
              state_n  = S_SETUP;
              cbitin_n = fifo_head_next;
              cnt_n    = half_m1;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            cnt_n = cnt_q - 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      confclk_q <= 1'b0;
      cbitin_q  <= '0;
      rdbk_q    <= '0;
      pulse_q   <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      confclk_q <= confclk_n;
      cbitin_q  <= cbitin_n;
      rdbk_q    <= rdbk_n;
      pulse_q   <= pulse_n;
    end
  end

endmodule

// File: tb/tb_morphle_cfg_loader.sv
// Directed bench for morphle_cfg_loader: Wishbone register traffic plus a
// confclk monitor that scores cbitin words and pulse timing against a queue.
module tb_morphle_cfg_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] wdat = '0;
  logic [31:0] adr = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        cfg_reset;
  logic        confclk;
  logic [15:0] cbitin;
  logic [15:0] cbitout = '0;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  // Scoreboard and monitor state
  logic [15:0] exp_q[$];
  int          fall_q[$];
  int          exp_half = 1;
  bit          hi_chk = 1'b1;
  logic        prev_cc = 1'b0;
  logic [15:0] prev_cb = '0;
  int          high_cnt = 0;
  int          low_cnt = 0;
  int          stable = 0;
  int          last_stable = 0;
  int          last_rise_cyc = 0;
  int          rise_total = 0;
  bit          idle_seen = 1'b1;
  bit          seen_fall = 1'b0;

  morphle_cfg_loader dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_dat_i   (wdat),
    .wbs_adr_i   (adr),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .cfg_reset_o (cfg_reset),
    .confclk_o   (confclk),
    .cbitin_o    (cbitin),
    .cbitout_i   (cbitout),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) idle_seen = 1'b1;
      if (confclk && !prev_cc) begin
        rise_total++;
        last_rise_cyc = cyc_cnt;
        last_stable = stable;
        check("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("cbitin_word", {16'h0, cbitin}, {16'h0, exp_q.pop_front()});
        if (!idle_seen && seen_fall) check("low_gap", low_cnt, exp_half);
        idle_seen = 1'b0;
        high_cnt = 1;
      end else if (confclk) begin
        high_cnt++;
      end
      if (!confclk && prev_cc) begin
        if (hi_chk) check("high_time", high_cnt, exp_half);
        fall_q.push_back(cyc_cnt);
        seen_fall = 1'b1;
        low_cnt = 1;
      end else if (!confclk) begin
        low_cnt++;
      end
      stable = (cbitin != prev_cb) ? 1 : stable + 1;
      prev_cc = confclk;
      prev_cb = cbitin;
    end
  end

  task automatic wb_xfer(input logic w, input logic [1:0] rsel, input logic [31:0] d,
                         output logic [31:0] r, output int waits, output int ack_at);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; adr = {28'h0, rsel, 2'b00}; wdat = d;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!ack && waits < 300);
    check("wb_ack", ack, 1'b1);
    r = rdat;
    ack_at = cyc_cnt;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    int w, t, t5, n;

    // 1. Reset state
    #12;
    check("rst_cfg_reset", cfg_reset, 1'b1);
    check("rst_confclk", confclk, 1'b0);
    check("rst_cbitin", {16'h0, cbitin}, 32'h0);
    check("rst_ack", ack, 1'b0);
    check("rst_dat", rdat, 32'h0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_xfer(1'b0, 2'd0, '0, r, w, t);
    check("ctrl_reset", r, 32'h0000_0101);
    check("ack_latency", w, 1);
    wb_xfer(1'b0, 2'd2, '0, r, w, t);
    check("status_reset", r, 32'h0000_0002);

    // 2. HALF=2, single word: latency, setup/high time, busy fall
    exp_half = 2;
    wb_xfer(1'b1, 2'd0, 32'h0000_0200, r, w, t);
    check("cfg_reset_released", cfg_reset, 1'b0);
    exp_q.push_back(16'hA5A5);
    wb_xfer(1'b1, 2'd1, 32'h0000_A5A5, r, w, t);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall_cycle", cyc_cnt - t, 2 + 2 * 2);
    check("rise_latency", last_rise_cyc - t, 2 + 2);
    check("setup_stable", last_stable, 2);
    check("confclk_low_after", confclk, 1'b0);
    wb_xfer(1'b0, 2'd2, '0, r, w, t);
    check("status_after_one", r, 32'h0001_0002);

    // 3. Readback of cbitout at the rise
    cbitout = 16'h1234;
    exp_q.push_back(16'h5A5A);
    wb_xfer(1'b1, 2'd1, 32'h0000_5A5A, r, w, t);
    wait_idle("idle_t3");
    cbitout = 16'hBEEF;
    wb_xfer(1'b0, 2'd3, '0, r, w, t);
    check("rdbk", r, 32'h0000_1234);
    wb_xfer(1'b0, 2'd1, '0, r, w, t);
    check("data_read_zero", r, 32'h0);

    // 4. HALF=8, five back-to-back words; the fifth stalls until the first pop
    exp_half = 8;
    wb_xfer(1'b1, 2'd0, 32'h0000_0800, r, w, t);
    fall_q.delete();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(16'(i * 16'h1111));
      wb_xfer(1'b1, 2'd1, 32'(i * 16'h1111), r, w, t);
      check("nostall_waits", w, 1);
    end
    wb_xfer(1'b0, 2'd2, '0, r, w, t);
    check("status_full", r, 32'h0002_0045);
    exp_q.push_back(16'h5555);
    wb_xfer(1'b1, 2'd1, 32'h0000_5555, r, w, t5);
    check("stalled_write", w > 1, 1'b1);
    wait_idle("idle_t4");
    check("stall_ack_at_pop", t5, fall_q.size() > 0 ? fall_q[0] : -1);
    check("sb_drained_t4", exp_q.size(), 0);
    wb_xfer(1'b0, 2'd2, '0, r, w, t);
    check("status_after_burst", r, 32'h0007_0002);

    // 5. HALF=0 behaves as 1; words preloaded under BLKRST, then released
    exp_half = 1;
    wb_xfer(1'b1, 2'd0, 32'h0000_0001, r, w, t);
    exp_q.push_back(16'h0F0F);
    wb_xfer(1'b1, 2'd1, 32'h0000_0F0F, r, w, t);
    exp_q.push_back(16'hF0F0);
    wb_xfer(1'b1, 2'd1, 32'h0000_F0F0, r, w, t);
    check("held_in_reset", confclk, 1'b0);
    wb_xfer(1'b1, 2'd0, 32'h0000_0000, r, w, t);
    wait_idle("idle_t5");
    check("sb_drained_t5", exp_q.size(), 0);
    wb_xfer(1'b0, 2'd2, '0, r, w, t);
    check("status_half0", r, 32'h0009_0002);

    // 6. BLKRST mid-burst aborts and flushes, pulse count kept
    exp_half = 8;
    wb_xfer(1'b1, 2'd0, 32'h0000_0800, r, w, t);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'hC000 + 16'(i));
      wb_xfer(1'b1, 2'd1, 32'hC000 + 32'(i), r, w, t);
    end
    n = 0;
    while (!confclk && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_rise_seen", confclk, 1'b1);
    hi_chk = 1'b0;
    wb_xfer(1'b1, 2'd0, 32'h0000_0801, r, w, t);
    @(negedge clk);
    check("abort_confclk", confclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_cfg_reset", cfg_reset, 1'b1);
    exp_q.delete();
    wb_xfer(1'b0, 2'd2, '0, r, w, t);
    check("abort_empty", r[1], 1'b1);
    check("abort_count", {16'h0, r[31:16]}, rise_total);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
